// File: rtl/nexys_starship_score_timer_pkg.sv
// Shared constants for the score/time keeper: FSM encodings and BCD limits.
package nexys_starship_score_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FROZEN = 2'd2
   } state_t;

   // Largest 4-digit packed BCD value; both counters saturate here.
   localparam logic [15:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/nexys_starship_score_timer_if.sv
// Game-side event inputs and BCD display outputs of the score timer.
interface nexys_starship_score_timer_if;
   logic        i_play_flag;
   logic        i_gameover_ctrl;
   logic        i_repair_done;
   logic        i_monster_cleared;
   logic [15:0] o_time_bcd;
   logic [15:0] o_score_bcd;
   logic [15:0] o_hiscore_bcd;
   logic        o_new_hiscore;
   logic        o_sec_tick;
   logic        o_running;

   // The timer block itself.
   modport slave (
      input  i_play_flag, i_gameover_ctrl, i_repair_done, i_monster_cleared,
      output o_time_bcd, o_score_bcd, o_hiscore_bcd, o_new_hiscore, o_sec_tick, o_running
   );

   // Game SMs / display mux side.
   modport master (
      output i_play_flag, i_gameover_ctrl, i_repair_done, i_monster_cleared,
      input  o_time_bcd, o_score_bcd, o_hiscore_bcd, o_new_hiscore, o_sec_tick, o_running
   );
endinterface

// File: rtl/nexys_starship_score_timer_bcd4.sv
// 4-digit packed BCD plus a single-digit addend, saturating at 9999.
module starship_bcd4_add_sat
   import nexys_starship_score_timer_pkg::*;
(
   input  logic [15:0] i_a,
   input  logic [3:0]  i_add,
   output logic [15:0] o_sum
);

   logic [3:0]  w_c;
   logic [4:0]  w_s;
   logic [15:0] w_sum;

   // Ripple the addend through the digits; the first digit takes the full addend,
   // the rest take a 0/1 carry. Carry out of the top digit means overflow -> 9999.
   always_comb begin
      w_c   = i_add;
      w_s   = '0;
      w_sum = '0;
      for (int i = 0; i < 4; i++) begin
         w_s = {1'b0, i_a[4*i +: 4]} + {1'b0, w_c};
         if (w_s > 5'd9) begin
            w_sum[4*i +: 4] = 4'(w_s - 5'd10);
            w_c             = 4'd1;
         end else begin
            w_sum[4*i +: 4] = w_s[3:0];
            w_c             = 4'd0;
         end
      end
      o_sum = (w_c != 4'd0) ? BCD_MAX : w_sum;
   end

endmodule

// File: rtl/nexys_starship_score_timer.sv
// Survival time, score and session high score, all as 4-digit packed BCD.
module nexys_starship_score_timer
   import nexys_starship_score_timer_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int REPAIR_PTS = 5,
   parameter int KILL_PTS   = 1
) (
   input  logic                         board_clk,
   input  logic                         Reset,
   nexys_starship_score_timer_if.slave  bus
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   // A single event cycle must never add more than one BCD digit's worth.
   if (REPAIR_PTS + KILL_PTS > 9) begin : g_pts_chk
      $error("REPAIR_PTS + KILL_PTS must not exceed 9");
   end

   state_t        r_state;
   logic [PW-1:0] r_presc;
   logic [15:0]   r_time;
   logic [15:0]   r_score;
   logic [15:0]   r_hiscore;
   logic          r_new_hi;
   logic          r_tick;

   logic [3:0]    w_add;
   logic [15:0]   w_time_inc;
   logic [15:0]   w_score_add;
   logic          w_sec_end;

   assign w_add = (bus.i_repair_done     ? 4'(REPAIR_PTS) : 4'd0)
                + (bus.i_monster_cleared ? 4'(KILL_PTS)   : 4'd0);
   assign w_sec_end = (r_presc == PW'(CLK_HZ - 1));

   starship_bcd4_add_sat u_time_add  (.i_a(r_time),  .i_add(4'd1),  .o_sum(w_time_inc));
   starship_bcd4_add_sat u_score_add (.i_a(r_score), .i_add(w_add), .o_sum(w_score_add));

   // Game FSM plus all counters; game-over wins over pulses and the second tick.
   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         r_state   <= ST_IDLE;
         r_presc   <= '0;
         r_time    <= '0;
         r_score   <= '0;
         r_hiscore <= '0;
         r_new_hi  <= 1'b0;
         r_tick    <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.i_play_flag && !bus.i_gameover_ctrl) begin
                  r_state  <= ST_RUN;
                  r_time   <= '0;
                  r_score  <= '0;
                  r_presc  <= '0;
                  r_new_hi <= 1'b0;
               end
            end
            ST_RUN: begin
               if (bus.i_gameover_ctrl) begin
                  r_state <= ST_FROZEN;
                  // Packed BCD orders like binary, so compare directly.
                  if (r_score > r_hiscore) begin
                     r_hiscore <= r_score;
                     r_new_hi  <= 1'b1;
                  end
               end else begin
                  if (!bus.i_play_flag) r_state <= ST_IDLE;
                  r_score <= w_score_add;
                  if (w_sec_end) begin
                     r_presc <= '0;
                     r_tick  <= 1'b1;
                     r_time  <= w_time_inc;
                  end else begin
                     r_presc <= r_presc + 1'b1;
                  end
               end
            end
            ST_FROZEN: begin
               if (!bus.i_play_flag) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_time_bcd    = r_time;
   assign bus.o_score_bcd   = r_score;
   assign bus.o_hiscore_bcd = r_hiscore;
   assign bus.o_new_hiscore = r_new_hi;
   assign bus.o_sec_tick    = r_tick;
   assign bus.o_running     = (r_state == ST_RUN);

endmodule

// File: tb/tb_nexys_starship_score_timer.sv
// Scoreboard bench for the score timer: a decimal reference model pushes the
// expected outputs per driven cycle; they are popped and compared after the edge.
module tb_nexys_starship_score_timer;

   localparam int HZ = 10;
   localparam int RP = 5;
   localparam int KP = 1;

   typedef struct {
      logic [15:0] t, s, h;
      logic        nh, tk, run;
   } exp_t;

   logic clk;
   logic rst;
   int   n_tot = 0;
   int   n_bad = 0;
   int   tick_cnt = 0;
   exp_t sb[$];

   // reference model state (decimal integers)
   int m_st, m_p, m_t, m_s, m_h, m_nh;

   nexys_starship_score_timer_if bus();

   nexys_starship_score_timer #(.CLK_HZ(HZ), .REPAIR_PTS(RP), .KILL_PTS(KP)) dut (
      .board_clk (clk),
      .Reset     (rst),
      .bus       (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] bcd(input int v);
      return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic model_reset();
      m_st = 0; m_p = 0; m_t = 0; m_s = 0; m_h = 0; m_nh = 0;
   endtask

   // Drive one cycle of inputs, predict, then compare after the edge.
   task automatic cyc(input logic pf, input logic go, input logic rd, input logic mc);
      exp_t e;
      int   add;
      logic tk;
      bus.i_play_flag       = pf;
      bus.i_gameover_ctrl   = go;
      bus.i_repair_done     = rd;
      bus.i_monster_cleared = mc;
      tk = 1'b0;
      case (m_st)
         0: if (pf && !go) begin
               m_st = 1; m_t = 0; m_s = 0; m_p = 0; m_nh = 0;
            end
         1: if (go) begin
               m_st = 2;
               if (m_s > m_h) begin m_h = m_s; m_nh = 1; end
            end else begin
               if (!pf) m_st = 0;
               add = (rd ? RP : 0) + (mc ? KP : 0);
               m_s = (m_s + add > 9999) ? 9999 : m_s + add;
               if (m_p == HZ - 1) begin
                  m_p = 0; tk = 1'b1;
                  if (m_t < 9999) m_t++;
               end else m_p++;
            end
         default: if (!pf) m_st = 0;
      endcase
      e.t = bcd(m_t); e.s = bcd(m_s); e.h = bcd(m_h);
      e.nh = m_nh[0]; e.tk = tk; e.run = (m_st == 1);
      sb.push_back(e);
      @(posedge clk);
      #1;
      tick_cnt += int'(bus.o_sec_tick);
      if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else begin
         e = sb.pop_front();
         chk("time",    32'(bus.o_time_bcd),    32'(e.t));
         chk("score",   32'(bus.o_score_bcd),   32'(e.s));
         chk("hiscore", 32'(bus.o_hiscore_bcd), 32'(e.h));
         chk("new_hi",  32'(bus.o_new_hiscore), 32'(e.nh));
         chk("tick",    32'(bus.o_sec_tick),    32'(e.tk));
         chk("running", 32'(bus.o_running),     32'(e.run));
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_time"},  32'(bus.o_time_bcd),    32'd0);
      chk({tag, "_score"}, 32'(bus.o_score_bcd),   32'd0);
      chk({tag, "_hi"},    32'(bus.o_hiscore_bcd), 32'd0);
      chk({tag, "_nh"},    32'(bus.o_new_hiscore), 32'd0);
      chk({tag, "_tick"},  32'(bus.o_sec_tick),    32'd0);
      chk({tag, "_run"},   32'(bus.o_running),     32'd0);
   endtask

   initial begin
      rst = 1'b1;
      bus.i_play_flag = 1'b0; bus.i_gameover_ctrl = 1'b0;
      bus.i_repair_done = 1'b0; bus.i_monster_cleared = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;

      // 1: three seconds of play
      tick_cnt = 0;
      repeat (35) cyc(1, 0, 0, 0);
      chk("t1_ticks", 32'(tick_cnt), 32'd3);
      chk("t1_time", 32'(bus.o_time_bcd), 32'h0003);
      chk("t1_run", 32'(bus.o_running), 32'd1);

      // 2: event scoring incl. both pulses in one cycle
      cyc(1, 0, 1, 0); cyc(1, 0, 0, 0); cyc(1, 0, 1, 0); cyc(1, 0, 0, 1); cyc(1, 0, 1, 1);
      chk("t2_score", 32'(bus.o_score_bcd), 32'h0017);
      cyc(1, 1, 0, 0);
      chk("t2_hi", 32'(bus.o_hiscore_bcd), 32'h0017);
      chk("t2_nh", 32'(bus.o_new_hiscore), 32'd1);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 1);
      chk("idle_pulse_ignored", 32'(bus.o_score_bcd), 32'h0017);
      // equal score does not flag a new high score
      cyc(1, 0, 0, 0);
      chk("restart_score", 32'(bus.o_score_bcd), 32'h0000);
      repeat (3) cyc(1, 0, 1, 0);
      repeat (2) cyc(1, 0, 0, 1);
      cyc(1, 1, 0, 0);
      chk("equal_nh", 32'(bus.o_new_hiscore), 32'd0);
      chk("equal_hi", 32'(bus.o_hiscore_bcd), 32'h0017);
      cyc(0, 0, 0, 0);

      // 3: score saturation
      cyc(1, 0, 0, 0);
      repeat (1998) cyc(1, 0, 1, 0);
      chk("t3_preload", 32'(bus.o_score_bcd), 32'h9990);
      repeat (3) cyc(1, 0, 1, 0);
      chk("t3_sat", 32'(bus.o_score_bcd), 32'h9999);

      // 4: game-over beats a coincident repair; lower replay keeps hiscore
      cyc(1, 1, 1, 0);
      chk("t4_score", 32'(bus.o_score_bcd), 32'h9999);
      chk("t4_hi", 32'(bus.o_hiscore_bcd), 32'h9999);
      chk("t4_nh", 32'(bus.o_new_hiscore), 32'd1);
      chk("t4_frozen", 32'(bus.o_running), 32'd0);
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      repeat (4) cyc(1, 0, 1, 0);
      repeat (5) cyc(1, 0, 0, 0);
      cyc(1, 1, 0, 0);  // would have been the first second tick
      chk("t4_tick_suppr", 32'(bus.o_time_bcd), 32'h0000);
      chk("t4_low_hi", 32'(bus.o_hiscore_bcd), 32'h9999);
      chk("t4_low_nh", 32'(bus.o_new_hiscore), 32'd0);
      chk("t4_low_score", 32'(bus.o_score_bcd), 32'h0020);
      cyc(0, 0, 0, 0);

      // 5: time carry 0099 -> 0100
      cyc(1, 0, 0, 0);
      repeat (990) cyc(1, 0, 0, 0);
      chk("t5_99", 32'(bus.o_time_bcd), 32'h0099);
      repeat (9) cyc(1, 0, 0, 0);
      chk("t5_hold", 32'(bus.o_time_bcd), 32'h0099);
      cyc(1, 0, 0, 0);
      chk("t5_100", 32'(bus.o_time_bcd), 32'h0100);

      // 6: asynchronous reset mid-game
      repeat (8) cyc(1, 0, 1, 0);
      repeat (2) cyc(1, 0, 0, 1);
      chk("t6_pre", 32'(bus.o_score_bcd), 32'h0042);
      #3;
      rst = 1'b1;
      #1;
      chk_all_zero("t6_async");
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(0, 0, 1, 0);
      cyc(1, 0, 0, 0);
      chk("t6_restart_run", 32'(bus.o_running), 32'd1);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
